// File: rtl/intr_ctrl.sv
// Interrupt controller feeding pfc.intr: latches and masks requests, acknowledges the lowest eligible index, holds off until iret.
// Build option: define INTR_EDGE_EN for rising-edge request detection; otherwise requests are level-sampled.
module intr_ctrl #(
  parameter int unsigned N_IRQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic             clk_pc,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             csr_we,
  input  logic [15:0]      csr_wdata,
  input  logic             iret,
  input  logic [15:0]      intr_ra,
  output logic             intr,
  output logic [ID_W-1:0]  intr_id,
  output logic             in_service,
  output logic [15:0]      saved_ra,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_SERVICE
  } state_e;

  state_e           state_q, state_d;
  logic             intr_q, intr_d;
  logic [ID_W-1:0]  intr_id_q, intr_id_d;
  logic [15:0]      saved_ra_q, saved_ra_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] irq_event;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] ack_clr;
  logic [ID_W-1:0]  win_idx;
  logic             win_found;
  logic             unused_wdata;

  assign unused_wdata = ^csr_wdata;

`ifdef INTR_EDGE_EN
  logic [N_IRQ-1:0] irq_q;

  always_ff @(posedge clk_pc) begin
    if (rst) irq_q <= '0;
    else     irq_q <= irq;
  end

  assign irq_event = irq & ~irq_q;
`else
  assign irq_event = irq;
`endif

  assign elig = pending_q & mask_q;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    win_idx   = '0;
    win_found = |elig;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (elig[i-1]) win_idx = ID_W'(i - 1);
    end
  end

  always_comb begin
    state_d    = state_q;
    intr_d     = 1'b0;
    intr_id_d  = intr_id_q;
    saved_ra_d = saved_ra_q;
    ack_clr    = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          intr_d    = 1'b1;
          intr_id_d = win_idx;
          ack_clr   = N_IRQ'(1) << win_idx;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        saved_ra_d = intr_ra;
        state_d    = S_SERVICE;
      end
      S_SERVICE: begin
        if (iret) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new request on the acknowledge edge re-pends the source (set beats clear).
  assign pending_d = (pending_q & ~ack_clr) | irq_event;
  assign mask_d    = csr_we ? csr_wdata[N_IRQ-1:0] : mask_q;

  always_ff @(posedge clk_pc) begin
    if (rst) begin
      state_q    <= S_IDLE;
      intr_q     <= 1'b0;
      intr_id_q  <= '0;
      saved_ra_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      intr_q     <= intr_d;
      intr_id_q  <= intr_id_d;
      saved_ra_q <= saved_ra_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
    end
  end

  assign intr       = intr_q;
  assign intr_id    = intr_id_q;
  assign in_service = (state_q == S_ACK) || (state_q == S_SERVICE);
  assign saved_ra   = saved_ra_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_intr_ctrl;

  localparam int N_IRQ = 4;
  localparam int ID_W  = 2;

  logic             clk_pc = 1'b0;
  logic             rst = 1'b1;
  logic [N_IRQ-1:0] irq = '0;
  logic             csr_we = 1'b0;
  logic [15:0]      csr_wdata = '0;
  logic             iret = 1'b0;
  logic [15:0]      intr_ra = '0;
  logic             intr;
  logic [ID_W-1:0]  intr_id;
  logic             in_service;
  logic [15:0]      saved_ra;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;

  int checks = 0;
  int errors = 0;

  intr_ctrl #(.N_IRQ(N_IRQ), .ID_W(ID_W)) dut (
    .clk_pc    (clk_pc),
    .rst       (rst),
    .irq       (irq),
    .csr_we    (csr_we),
    .csr_wdata (csr_wdata),
    .iret      (iret),
    .intr_ra   (intr_ra),
    .intr      (intr),
    .intr_id   (intr_id),
    .in_service(in_service),
    .saved_ra  (saved_ra),
    .pending   (pending),
    .mask      (mask)
  );

  always #5 clk_pc = ~clk_pc;

  // Behavioural model: phase 0 = waiting, 1 = acknowledging, 2 = servicing.
  int         m_phase = 0;
  bit [3:0]   m_pend = '0, m_mask = '0, m_irq_prev = '0;
  bit         m_intr = 1'b0;
  bit [1:0]   m_id = '0;
  bit [15:0]  m_ra = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest_index(input bit [3:0] v);
    bit [3:0] iso;
    iso = v & (~v + 4'd1);
    return $clog2(iso);
  endfunction

  task automatic model_step();
    bit [3:0] ev, elig;
    int       w;
    if (rst) begin
      m_phase = 0; m_pend = '0; m_mask = '0; m_irq_prev = '0;
      m_intr = 0; m_id = '0; m_ra = '0;
      return;
    end
`ifdef INTR_EDGE_EN
    ev = irq & ~m_irq_prev;
`else
    ev = irq;
`endif
    m_irq_prev = irq;
    elig = m_pend & m_mask;
    m_intr = 0;
    if (m_phase == 0) begin
      if (elig != 0) begin
        w = lowest_index(elig);
        m_id = 2'(w);
        m_pend[w] = 1'b0;
        m_intr = 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_ra = intr_ra;
      m_phase = 2;
    end else if (iret) begin
      m_phase = 0;
    end
    m_pend = m_pend | ev;
    if (csr_we) m_mask = csr_wdata[3:0];
  endtask

  task automatic cycle();
    @(posedge clk_pc);
    #1;
    model_step();
    check("intr", intr, m_intr);
    check("intr_id", intr_id, m_id);
    check("in_service", in_service, m_phase != 0);
    check("saved_ra", saved_ra, m_ra);
    check("pending", pending, m_pend);
    check("mask", mask, m_mask);
  endtask

  task automatic do_reset();
    rst = 1; irq = '0; csr_we = 0; iret = 0;
    cycle(); cycle();
    rst = 0;
  endtask

  task automatic write_mask(input logic [15:0] v);
    csr_we = 1; csr_wdata = v;
    cycle();
    csr_we = 0;
  endtask

  task automatic wait_intr(input string tag, input int budget);
    int n = 0;
    while (intr !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_timeout"}, intr, 1'b1);
  endtask

  task automatic finish_service();
    int n = 0;
    while (!(in_service && !intr) && n < 8) begin
      cycle();
      n++;
    end
    iret = 1;
    cycle();
    iret = 0;
  endtask

  initial begin
    int pulses;

    // Reset with all requests raised but everything masked.
    rst = 1; irq = 4'b1111;
    cycle(); cycle();
    rst = 0;
    cycle();
    check("rst_pending", pending, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rst_no_intr", intr, 1'b0);
    end
    check("rst_saved_ra", saved_ra, 16'h0000);
    check("rst_mask", mask, 4'b0000);

    // Single interrupt with the documented latency.
    do_reset();
    write_mask(16'h0004);
    intr_ra = 16'h1234;
    irq = 4'b0100;
    cycle();
    check("single_pend", pending[2], 1'b1);
    irq = '0;
    cycle();
    check("single_intr", intr, 1'b1);
    check("single_id", intr_id, 2'd2);
    check("single_pend_clr", pending[2], 1'b0);
    cycle();
    check("single_intr_low", intr, 1'b0);
    check("single_ra", saved_ra, 16'h1234);
    cycle(); cycle();
    check("single_insvc", in_service, 1'b1);
    iret = 1;
    cycle();
    iret = 0;
    check("single_done", in_service, 1'b0);

    // Priority between simultaneous requests, with a gap between services.
    write_mask(16'h000F);
    irq = 4'b1010;
    cycle();
    irq = '0;
    wait_intr("prio1", 6);
    check("prio_first", intr_id, 2'd1);
    cycle(); cycle();
    iret = 1;
    cycle();
    iret = 0;
    check("prio_gap", intr, 1'b0);
    cycle();
    check("prio_second", intr, 1'b1);
    check("prio_second_id", intr_id, 2'd3);
    finish_service();

    // No nesting while in service.
    irq = 4'b0100;
    cycle();
    irq = '0;
    wait_intr("nest", 6);
    cycle(); cycle();
    irq = 4'b0001;
    cycle();
    irq = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("nest_hold", intr, 1'b0);
    end
    iret = 1;
    cycle();
    iret = 0;
    wait_intr("nest_after", 4);
    check("nest_id", intr_id, 2'd0);
    finish_service();

    // Mask gating, then reset in the middle of a service.
    do_reset();
    irq = 4'b1000;
    cycle();
    irq = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("mask_hold", intr, 1'b0);
    end
    check("mask_pend", pending[3], 1'b1);
    write_mask(16'h0008);
    check("mask_visible_no_intr", intr, 1'b0);
    cycle();
    check("mask_intr", intr, 1'b1);
    check("mask_id", intr_id, 2'd3);
    cycle(); cycle();
    rst = 1;
    cycle();
    rst = 0;
    check("mid_rst_intr", intr, 1'b0);
    check("mid_rst_insvc", in_service, 1'b0);
    check("mid_rst_ra", saved_ra, 16'h0000);
    check("mid_rst_pend", pending, 4'b0000);
    check("mid_rst_mask", mask, 4'b0000);
    check("mid_rst_id", intr_id, 2'd0);

    // A request line held high for ten cycles.
    write_mask(16'h0002);
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      irq = (i < 10) ? 4'b0010 : 4'b0000;
      iret = in_service && !intr;
      cycle();
      if (intr) pulses++;
    end
    iret = 0;
`ifdef INTR_EDGE_EN
    check("held_pulses", pulses, 1);
`else
    check("held_repend", pulses > 1, 1'b1);
`endif

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      irq       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      csr_we    = ($urandom_range(0, 15) == 0);
      csr_wdata = 16'($urandom);
      iret      = ($urandom_range(0, 3) == 0);
      intr_ra   = 16'($urandom);
      rst       = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
